// File: rtl/weight_bank_pkg.sv
// Shared types and helpers for the weight_bank layer store.
package weight_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int flat_idx(input int i, input int j, input int n_out);
        return i * n_out + j;
    endfunction

    // Limits are returned wide and truncated by the user to W bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/weight_bank_sat_add.sv
// Combinational W-bit signed adder that clamps instead of wrapping.
module weight_bank_sat_add
    import weight_bank_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] MAX_V = W'(sat_max(W));
    localparam logic [W-1:0] MIN_V = W'(sat_min(W));

    logic [W:0] sum_s;

    assign sum_s = {a[W-1], a} + {b[W-1], b};

    // Clamp when the two top bits of the W+1-bit sum disagree.
    always_comb begin
        y = sum_s[W-1:0];
        if (sum_s[W] != sum_s[W-1]) begin
            if (sum_s[W]) begin
                y = MIN_V;
            end else begin
                y = MAX_V;
            end
        end else begin
            y = sum_s[W-1:0];
        end
    end

endmodule

// File: rtl/weight_bank.sv
// N_IN x N_OUT signed weight store with column-sequential saturating update.
// INIT_IMAGE holds the w3.mif contents; define WEIGHT_BANK_TARGET_EN for the target-network copy.
module weight_bank
    import weight_bank_pkg::*;
#(
    parameter int                        N_IN       = 5,
    parameter int                        N_OUT      = 4,
    parameter int                        W          = 16,
    parameter logic [3:0]                UPD_CTRL   = 4'b0011,
    parameter logic [N_IN*N_OUT*W-1:0]   INIT_IMAGE = {(N_IN*N_OUT){W'(16'h0100)}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                ctrl,
    input  logic [3:0]                step,
    input  logic [N_IN*N_OUT*W-1:0]   deltaw,
    output logic [N_IN*N_OUT*W-1:0]   w,
    output logic                      busy,
    output logic                      done
`ifdef WEIGHT_BANK_TARGET_EN
    ,
    input  logic                      sync_target,
    output logic [N_IN*N_OUT*W-1:0]   w_tgt
`endif
);

    localparam int             CW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [CW-1:0]  COL_LAST = CW'(N_OUT - 1);

    state_t         state_r;
    state_t         state_nxt;
    logic [CW-1:0]  col_r;
    logic [CW-1:0]  col_nxt;
    logic           trig_s;
    logic           trig_q_r;
    logic           start_s;
    logic           busy_r;
    logic           done_r;

    logic [W-1:0]   w_r     [N_IN][N_OUT];
    logic [W-1:0]   init_s  [N_IN][N_OUT];
    logic [W-1:0]   delta_s [N_IN][N_OUT];
    logic [W-1:0]   sum_s   [N_IN];

`ifdef WEIGHT_BANK_TARGET_EN
    logic [W-1:0]   tgt_r   [N_IN][N_OUT];
    logic           pend_r;
`endif

    assign trig_s  = (step != 4'd0) && (ctrl == UPD_CTRL);
    assign start_s = trig_s && !trig_q_r && (state_r == IDLE);
    assign busy    = busy_r;
    assign done    = done_r;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_row
        for (genvar gj = 0; gj < N_OUT; gj++) begin : g_col
            assign init_s[gi][gj]  = INIT_IMAGE[flat_idx(gi, gj, N_OUT)*W +: W];
            assign delta_s[gi][gj] = deltaw[flat_idx(gi, gj, N_OUT)*W +: W];
            assign w[flat_idx(gi, gj, N_OUT)*W +: W] = w_r[gi][gj];
`ifdef WEIGHT_BANK_TARGET_EN
            assign w_tgt[flat_idx(gi, gj, N_OUT)*W +: W] = tgt_r[gi][gj];
`endif
        end

        weight_bank_sat_add #(
            .W (W)
        ) u_sat_add (
            .a (w_r[gi][col_r]),
            .b (delta_s[gi][col_r]),
            .y (sum_s[gi])
        );
    end

    // Next-state and column-pointer logic.
    always_comb begin
        state_nxt = state_r;
        col_nxt   = col_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt = UPDATE;
                    col_nxt   = {CW{1'b0}};
                end else begin
                    state_nxt = IDLE;
                end
            end
            UPDATE: begin
                if (col_r == COL_LAST) begin
                    state_nxt = DONE;
                end else begin
                    col_nxt = col_r + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                col_nxt   = {CW{1'b0}};
            end
            default: begin
                state_nxt = IDLE;
                col_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // State, trigger history and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            col_r    <= {CW{1'b0}};
            trig_q_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            col_r    <= col_nxt;
            trig_q_r <= trig_s;
            busy_r   <= (state_nxt == UPDATE);
            done_r   <= (state_nxt == DONE);
        end
    end

    // Weight array: reload on reset, otherwise commit one column per UPDATE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_r <= init_s;
        end else if (state_r == UPDATE) begin
            for (int i = 0; i < N_IN; i++) begin
                w_r[i][col_r] <= sum_s[i];
            end
        end
    end

`ifdef WEIGHT_BANK_TARGET_EN
    // Target copy happens only from IDLE so it never captures a half-updated array.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_r  <= init_s;
            pend_r <= 1'b0;
        end else if ((state_r == IDLE) && (sync_target || pend_r)) begin
            tgt_r  <= w_r;
            pend_r <= 1'b0;
        end else if (sync_target) begin
            pend_r <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_bank.sv
// Scoreboard bench for weight_bank: stimulus pushes expectations, a negedge monitor checks them.
module tb_weight_bank;

    localparam int NI = 5;
    localparam int NO = 4;
    localparam int WW = 16;
    localparam int NB = NI * NO * WW;

    logic            clk;
    logic            rst;
    logic [3:0]      ctrl;
    logic [3:0]      step;
    logic [NB-1:0]   deltaw;
    logic [NB-1:0]   w;
    logic            busy;
    logic            done;
`ifdef WEIGHT_BANK_TARGET_EN
    logic            sync_target;
    logic [NB-1:0]   w_tgt;
`endif

    weight_bank #(
        .N_IN       (NI),
        .N_OUT      (NO),
        .W          (WW),
        .UPD_CTRL   (4'b0011),
        .INIT_IMAGE ({(NI*NO){16'h0100}})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (ctrl),
        .step        (step),
        .deltaw      (deltaw),
        .w           (w),
        .busy        (busy),
        .done        (done)
`ifdef WEIGHT_BANK_TARGET_EN
        ,
        .sync_target (sync_target),
        .w_tgt       (w_tgt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] oldv;
        logic [NB-1:0] newv;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          busy_total = 0;
    int          bcnt = 0;
    logic [15:0] mw [NI][NO];
    logic [15:0] md [NI][NO];

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] pack(input logic [15:0] a [NI][NO]);
        logic [NB-1:0] v;
        v = '0;
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                v[(i*NO+j)*WW +: WW] = a[i][j];
        return v;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    // Columns below k already committed, the rest still old.
    function automatic logic [NB-1:0] mix(input logic [NB-1:0] oldv, input logic [NB-1:0] newv, input int k);
        logic [NB-1:0] v;
        v = oldv;
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                if (j < k) v[(i*NO+j)*WW +: WW] = newv[(i*NO+j)*WW +: WW];
        return v;
    endfunction

    function automatic logic [15:0] el(input logic [NB-1:0] v, input int i, input int j);
        return v[(i*NO+j)*WW +: WW];
    endfunction

    task automatic clr_md(input logic [15:0] val);
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                md[i][j] = val;
    endtask

    // Monitor: per-cycle column commit checks and end-of-update comparison.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            bcnt = 0;
        end else begin
            if (busy === 1'b1) begin
                if (sbq.size() > 0) check("col_commit", w, mix(sbq[0].oldv, sbq[0].newv, bcnt));
                bcnt++;
                busy_total++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending update");
                end else begin
                    mon_e = sbq.pop_front();
                    check("w_after_done", w, mon_e.newv);
                    check("busy_cycles", NB'(bcnt), NB'(NO));
                end
                bcnt = 0;
            end
            if (busy !== 1'b1 && done !== 1'b1) bcnt = 0;
        end
    end

    task automatic apply_update(input bit reenter);
        exp_t e;
        int   d0;
        e.oldv = pack(mw);
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                mw[i][j] = sat16(mw[i][j], md[i][j]);
        e.newv = pack(mw);
        sbq.push_back(e);
        deltaw = pack(md);
        d0 = done_cnt;
        @(posedge clk); #1;
        step = 4'd1;
        ctrl = 4'b0011;
        if (reenter) begin
            repeat (2) @(posedge clk);
            #1 ctrl = 4'b0000;
            @(posedge clk);
            #1 ctrl = 4'b0011;
        end
        repeat (20) @(posedge clk);
        #1 ctrl = 4'b0000;
        step = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", NB'(done_cnt - d0), NB'(1));
        check("sb_drained", NB'(sbq.size()), NB'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int d0;
        rst = 1'b1;
        ctrl = 4'b0000;
        step = 4'd0;
        deltaw = '0;
`ifdef WEIGHT_BANK_TARGET_EN
        sync_target = 1'b0;
`endif
        clr_md(16'h0000);
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                mw[i][j] = 16'h0100;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_w", w, {(NI*NO){16'h0100}});
        check("reset_busy", NB'(busy), NB'(0));
        check("reset_done", NB'(done), NB'(0));
`ifdef WEIGHT_BANK_TARGET_EN
        check("reset_w_tgt", w_tgt, {(NI*NO){16'h0100}});
`endif

        // Single update with a ctrl re-entry while busy, which must be ignored.
        clr_md(16'h0010);
        apply_update(1'b1);
        check("upd1_all", w, {(NI*NO){16'h0110}});

        // step==0 gates the trigger.
        b0 = busy_total;
        step = 4'd0;
        ctrl = 4'b0011;
        repeat (10) @(posedge clk);
        #1 ctrl = 4'b0000;
        check("gate_no_busy", NB'(busy_total - b0), NB'(0));
        check("gate_w", w, {(NI*NO){16'h0110}});

        // Fresh entry after done gives a second update.
        apply_update(1'b0);
        check("upd2_all", w, {(NI*NO){16'h0120}});

        clr_md(16'h0000);
        md[2][1] = 16'h7ED0;
        md[0][3] = 16'h8000;
        apply_update(1'b0);
        clr_md(16'h0000);
        md[0][3] = 16'hFEF0;
        apply_update(1'b0);
        check("pre_sat_21", NB'(el(w, 2, 1)), NB'(16'h7FF0));
        check("pre_sat_03", NB'(el(w, 0, 3)), NB'(16'h8010));

        clr_md(16'h0000);
        md[2][1] = 16'h0020;
        md[0][3] = 16'hFFE0;
        md[4][0] = 16'h7FFF;
        md[1][2] = 16'h8000;
        apply_update(1'b0);
        check("sat_ovf_21", NB'(el(w, 2, 1)), NB'(16'h7FFF));
        check("sat_unf_03", NB'(el(w, 0, 3)), NB'(16'h8000));
        check("sat_ovf_40", NB'(el(w, 4, 0)), NB'(16'h7FFF));
        check("nosat_12", NB'(el(w, 1, 2)), NB'(16'h8120));

`ifdef WEIGHT_BANK_TARGET_EN
        // sync_target during busy is deferred until the update finishes.
        clr_md(16'h0001);
        deltaw = pack(md);
        sbq.push_back('{oldv: pack(mw), newv: '0});
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                mw[i][j] = sat16(mw[i][j], md[i][j]);
        sbq[sbq.size()-1].newv = pack(mw);
        @(posedge clk); #1;
        step = 4'd1;
        ctrl = 4'b0011;
        repeat (2) @(posedge clk);
        #1 sync_target = 1'b1;
        @(posedge clk);
        #1 sync_target = 1'b0;
        repeat (20) @(posedge clk);
        #1 ctrl = 4'b0000;
        step = 4'd0;
        check("w_tgt_sync", w_tgt, pack(mw));
`endif

        // Reset in the second UPDATE cycle discards the partial update.
        clr_md(16'h0040);
        deltaw = pack(md);
        @(posedge clk); #1;
        step = 4'd1;
        ctrl = 4'b0011;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_col0_new", NB'(el(w, 0, 0)), NB'(sat16(mw[0][0], 16'h0040)));
        check("mid_col1_old", NB'(el(w, 0, 1)), NB'(mw[0][1]));
        rst = 1'b1;
        ctrl = 4'b0000;
        step = 4'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_cnt;
        check("rst_mid_w", w, {(NI*NO){16'h0100}});
        check("rst_mid_busy", NB'(busy), NB'(0));
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid_no_done", NB'(done_cnt - d0), NB'(0));
        check("final_sb_empty", NB'(sbq.size()), NB'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
